ksa_stream_accumulator: RTL and testbench

- Sequential consumer stage built around one combinational kogge_stone_adder instance (PRECISION-bit, result plus carry-out).
- Accepts a packetised stream of PRECISION-bit words over valid/ready and accumulates them modulo 2^PRECISION.
- Tracks a sticky overflow and a beat count per packet.
- Presents the packet total on a valid/ready output with full backpressure; feeds downstream datapath logic.

---
 rtl/ksa_stream_accumulator.sv | 136 +++++++++++++
 tb/tb_ksa_stream_accumulator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ksa_stream_accumulator.sv
// Packet accumulator: sums a valid/ready word stream through a Kogge-Stone adder and
// presents the per-packet total, sticky carry flag and saturating beat count.
//
// state | meaning
// IDLE  | no beat of the current packet accepted yet, acc/ovf/cnt are zero
// ACCUM | mid-packet, accepting beats until one arrives with in_last_i
// DONE  | packet result on the output, input stalled until the output handshake

module kogge_stone_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_o
);
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen_nxt;
    logic [WIDTH-1:0] prop_nxt;

    // Prefix tree: each level combines group (g, p) pairs at span d.
    always_comb begin
        gen      = a_i & b_i;
        prop     = a_i ^ b_i;
        gen_nxt  = gen;
        prop_nxt = prop;
        for (int d = 1; d < WIDTH; d = d * 2) begin
            gen_nxt  = gen;
            prop_nxt = prop;
            for (int i = d; i < WIDTH; i++) begin
                gen_nxt[i]  = gen[i] | (prop[i] & gen[i-d]);
                prop_nxt[i] = prop[i] & prop[i-d];
            end
            gen  = gen_nxt;
            prop = prop_nxt;
        end
        result_o   = (a_i ^ b_i) ^ {gen[WIDTH-2:0], 1'b0};
        overflow_o = gen[WIDTH-1];
    end
endmodule

module ksa_stream_accumulator #(
    parameter int PRECISION = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PRECISION-1:0] in_data_i,
    input  logic                 in_last_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PRECISION-1:0] out_sum_o,
    output logic                 out_overflow_o,
    output logic [CNT_WIDTH-1:0] out_count_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PRECISION-1:0]   acc;
    logic [PRECISION-1:0]   acc_next;
    logic                   ovf;
    logic                   ovf_next;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic [PRECISION-1:0]   add_sum;
    logic                   add_carry;
    logic                   accept;

    kogge_stone_adder #(.WIDTH(PRECISION)) u_adder (
        .a_i       (acc),
        .b_i       (in_data_i),
        .result_o  (add_sum),
        .overflow_o(add_carry)
    );

    // Handshake flags decode the state register only, so neither side sees a comb path.
    assign in_ready_o     = (state != DONE);
    assign out_valid_o    = (state == DONE);
    assign accept         = in_valid_i & in_ready_o;
    assign out_sum_o      = acc;
    assign out_overflow_o = ovf;
    assign out_count_o    = cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            ovf   <= ovf_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        ovf_next   = ovf;
        cnt_next   = cnt;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_next   = add_sum;
                    ovf_next   = ovf | add_carry;
                    cnt_next   = (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + CNT_WIDTH'(1);
                    state_next = in_last_i ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_next = IDLE;
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                acc_next   = '0;
                ovf_next   = 1'b0;
                cnt_next   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_ksa_stream_accumulator.sv
// Scoreboard bench for ksa_stream_accumulator: directed packets push expected results,
// monitors pop and compare on every output handshake.

module tb_ksa_stream_accumulator;
    typedef struct {
        logic [7:0] sum;
        logic       ovf;
        logic [7:0] cnt;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_sum;
    logic       out_ovf;
    logic [7:0] out_cnt;

    logic       in_valid2 = 1'b0;
    logic       in_ready2;
    logic [7:0] in_data2 = 8'd0;
    logic       in_last2 = 1'b0;
    logic       out_valid2;
    logic       out_ready2 = 1'b1;
    logic [7:0] out_sum2;
    logic       out_ovf2;
    logic [1:0] out_cnt2;

    exp_t q[$];
    exp_t q2[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk_i = ~clk_i;

    ksa_stream_accumulator #(.PRECISION(8), .CNT_WIDTH(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_sum_o(out_sum), .out_overflow_o(out_ovf), .out_count_o(out_cnt)
    );

    ksa_stream_accumulator #(.PRECISION(8), .CNT_WIDTH(2)) dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid2), .in_ready_o(in_ready2), .in_data_i(in_data2), .in_last_i(in_last2),
        .out_valid_o(out_valid2), .out_ready_i(out_ready2),
        .out_sum_o(out_sum2), .out_overflow_o(out_ovf2), .out_count_o(out_cnt2)
    );

    always @(negedge clk_i) begin
        if (rst_ni && out_valid && out_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL main_unexpected_output got sum=%0d ovf=%0d cnt=%0d, no packet expected",
                         out_sum, out_ovf, out_cnt);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out_sum !== e.sum || out_ovf !== e.ovf || out_cnt !== e.cnt) begin
                    bad++;
                    $display("FAIL main_result got sum=%0d ovf=%0d cnt=%0d want sum=%0d ovf=%0d cnt=%0d",
                             out_sum, out_ovf, out_cnt, e.sum, e.ovf, e.cnt);
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni && out_valid2 && out_ready2) begin
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL sat_unexpected_output got sum=%0d cnt=%0d, no packet expected",
                         out_sum2, out_cnt2);
            end else begin
                exp_t e;
                e = q2.pop_front();
                if (out_sum2 !== e.sum || out_ovf2 !== e.ovf || 8'(out_cnt2) !== e.cnt) begin
                    bad++;
                    $display("FAIL sat_result got sum=%0d ovf=%0d cnt=%0d want sum=%0d ovf=%0d cnt=%0d",
                             out_sum2, out_ovf2, out_cnt2, e.sum, e.ovf, e.cnt);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic expect_pkt(input bit sel, input logic [7:0] s, input logic o, input logic [7:0] c);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        e.cnt = c;
        if (sel) q2.push_back(e);
        else q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send_beat(input bit sel, input logic [7:0] d, input logic last);
        logic rdy;
        int   n;
        n = 0;
        if (sel) begin in_valid2 = 1'b1; in_data2 = d; in_last2 = last; end
        else begin in_valid = 1'b1; in_data = d; in_last = last; end
        do begin
            @(negedge clk_i);
            rdy = sel ? in_ready2 : in_ready;
            @(posedge clk_i);
            #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL beat_timeout data=%0d got ready=0 want ready=1 within 50 cycles", d);
        end
        if (sel) begin in_valid2 = 1'b0; in_data2 = 8'hxx; in_last2 = 1'bx; end
        else begin in_valid = 1'b0; in_data = 8'hxx; in_last = 1'bx; end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        idle_cycles(3);
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_sum", 32'(out_sum), 0);
        check("reset_ovf", 32'(out_ovf), 0);
        check("reset_cnt", 32'(out_cnt), 0);

        expect_pkt(0, 8'd200, 1'b0, 8'd1);
        send_beat(0, 8'd200, 1'b1);
        check("single_valid_next_cycle", 32'(out_valid), 1);
        idle_cycles(1);
        check("single_back_idle_ready", 32'(in_ready), 1);
        check("single_back_idle_valid", 32'(out_valid), 0);

        expect_pkt(0, 8'd123, 1'b0, 8'd3);
        send_beat(0, 8'd10, 1'b0);
        send_beat(0, 8'd25, 1'b0);
        idle_cycles(2);
        check("bubble_hold_sum", 32'(out_sum), 35);
        send_beat(0, 8'd88, 1'b1);
        idle_cycles(1);

        expect_pkt(0, 8'd0, 1'b1, 8'd2);
        send_beat(0, 8'd255, 1'b0);
        send_beat(0, 8'd1, 1'b1);
        idle_cycles(1);

        expect_pkt(0, 8'd54, 1'b1, 8'd3);
        send_beat(0, 8'd150, 1'b0);
        send_beat(0, 8'd150, 1'b0);
        send_beat(0, 8'd10, 1'b1);
        idle_cycles(1);

        out_ready = 1'b0;
        expect_pkt(0, 8'd16, 1'b0, 8'd2);
        send_beat(0, 8'd7, 1'b0);
        send_beat(0, 8'd9, 1'b1);
        in_valid = 1'b1; in_data = 8'd99; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_sum_stable", 32'(out_sum), 16);
            check("bp_cnt_stable", 32'(out_cnt), 2);
            @(posedge clk_i); #1;
        end
        out_ready = 1'b1;
        expect_pkt(0, 8'd99, 1'b0, 8'd1);
        send_beat(0, 8'd99, 1'b1);
        idle_cycles(1);

        send_beat(0, 8'd40, 1'b0);
        send_beat(0, 8'd50, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_async_sum", 32'(out_sum), 0);
        check("rst_async_cnt", 32'(out_cnt), 0);
        check("rst_async_ready", 32'(in_ready), 1);
        check("rst_async_valid", 32'(out_valid), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        expect_pkt(0, 8'd5, 1'b0, 8'd1);
        send_beat(0, 8'd5, 1'b1);
        idle_cycles(1);

        expect_pkt(1, 8'd5, 1'b0, 8'd3);
        for (int i = 0; i < 5; i++) send_beat(1, 8'd1, (i == 4));
        idle_cycles(3);

        check("main_queue_drained", 32'(q.size()), 0);
        check("sat_queue_drained", 32'(q2.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
